// File: rtl/mulpop_arbiter.sv
// Two-requester shift-add multiplier (24x24 -> 48) with popcount of the low word.
// Round-robin arbitration between two level-sensitive requesters; one operation
// in flight at a time: grant, 24 multiply steps, one count/publish cycle, one idle-return cycle.
module mulpop_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [23:0] a1_0,
  input  logic [23:0] a2_0,
  input  logic [23:0] a1_1,
  input  logic [23:0] a2_1,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic        busy,
  output logic [31:0] w,
  output logic [5:0]  l,
  output logic        valid,
  output logic        owner,
  output logic [15:0] op_count
);

  localparam int unsigned OPW  = 24;
  localparam int unsigned ACCW = 48;
  localparam int unsigned KW   = 5;
  localparam int unsigned WW   = 32;
  localparam int unsigned LW   = 6;
  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              rr, rr_n;
  logic              g, g_n;
  logic              gsel;
  logic [OPW-1:0]    a1, a1_n;
  logic [OPW-1:0]    a2, a2_n;
  logic [ACCW-1:0]   acc, acc_n;
  logic [KW-1:0]     k, k_n;
  logic [1:0]        ack_n, done_n;
  logic              busy_n;
  logic [WW-1:0]     w_n;
  logic [LW-1:0]     l_n;
  logic              valid_n;
  logic              owner_n;
  logic [CNTW-1:0]   op_count_n;

  // Number of set bits in a 32-bit word (0..32).
  function automatic logic [LW-1:0] popcount32(input logic [WW-1:0] v);
    logic [LW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(WW); i++) begin
      s = s + LW'(v[i]);
    end
    return s;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    rr_n       = rr;
    g_n        = g;
    gsel       = 1'b0;
    a1_n       = a1;
    a2_n       = a2;
    acc_n      = acc;
    k_n        = k;
    ack_n      = 2'b00;
    done_n     = 2'b00;
    w_n        = w;
    l_n        = l;
    valid_n    = valid;
    owner_n    = owner;
    op_count_n = op_count;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // With both requesting the pointer decides; otherwise the lone requester wins.
          gsel    = (req == 2'b11) ? rr : req[1];
          a1_n    = gsel ? a1_1 : a1_0;
          a2_n    = gsel ? a2_1 : a2_0;
          acc_n   = '0;
          k_n     = '0;
          ack_n   = gsel ? 2'b10 : 2'b01;
          rr_n    = ~gsel;
          g_n     = gsel;
          state_n = MULT;
        end
      end
      MULT: begin
        if (a2[k]) begin
          acc_n = acc + (ACCW'(a1) << k);
        end
        k_n = k + KW'(1);
        if (k == KW'(OPW - 1)) begin
          state_n = COUNT;
        end
      end
      COUNT: begin
        w_n        = acc[WW-1:0];
        valid_n    = (acc[ACCW-1:WW] == '0);
        l_n        = popcount32(acc[WW-1:0]);
        owner_n    = g;
        done_n     = g ? 2'b10 : 2'b01;
        op_count_n = op_count + CNTW'(1);
        state_n    = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      g        <= 1'b0;
      a1       <= '0;
      a2       <= '0;
      acc      <= '0;
      k        <= '0;
      ack      <= 2'b00;
      done     <= 2'b00;
      busy     <= 1'b0;
      w        <= '0;
      l        <= '0;
      valid    <= 1'b1;
      owner    <= 1'b0;
      op_count <= '0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      g        <= g_n;
      a1       <= a1_n;
      a2       <= a2_n;
      acc      <= acc_n;
      k        <= k_n;
      ack      <= ack_n;
      done     <= done_n;
      busy     <= busy_n;
      w        <= w_n;
      l        <= l_n;
      valid    <= valid_n;
      owner    <= owner_n;
      op_count <= op_count_n;
    end
  end

endmodule

// File: tb/tb_mulpop_arbiter.sv
// Directed bench for mulpop_arbiter: vector table plus hand-written corner sequences.
module tb_mulpop_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [23:0] a1_0, a2_0, a1_1, a2_1;
  logic [1:0]  ack, done;
  logic        busy;
  logic [31:0] w;
  logic [5:0]  l;
  logic        valid;
  logic        owner;
  logic [15:0] op_count;

  int checks;
  int failures;
  logic [15:0] exp_opc;

  mulpop_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .a1_0(a1_0), .a2_0(a2_0), .a1_1(a1_1), .a2_1(a2_1),
    .ack(ack), .done(done), .busy(busy),
    .w(w), .l(l), .valid(valid), .owner(owner), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [23:0] a10, a20, a11, a21;
    logic        exp_owner;
    logic [31:0] exp_w;
    logic [5:0]  exp_l;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, 48'(busy), 48'd0);
    check({tag, " ack"}, 48'(ack), 48'd0);
    check({tag, " done"}, 48'(done), 48'd0);
    check({tag, " w"}, 48'(w), 48'd0);
    check({tag, " l"}, 48'(l), 48'd0);
    check({tag, " valid"}, 48'(valid), 48'd1);
    check({tag, " owner"}, 48'(owner), 48'd0);
    check({tag, " op_count"}, 48'(op_count), 48'd0);
  endtask

  // Wait (at negedges) for a nonzero ack; found=0 on timeout.
  task automatic wait_ack(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Count negedges until done pulses; n = -1 on timeout.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        n = i;
        break;
      end
    end
  endtask

  // One full operation; operands are scrambled right after the grant.
  task automatic run_op(input string tag, input vec_t v);
    bit found;
    int n;
    req = v.req; a1_0 = v.a10; a2_0 = v.a20; a1_1 = v.a11; a2_1 = v.a21;
    wait_ack(40, found);
    check({tag, " ack seen"}, 48'(found), 48'd1);
    check({tag, " ack index"}, 48'(ack), v.exp_owner ? 48'd2 : 48'd1);
    check({tag, " busy at ack"}, 48'(busy), 48'd1);
    req = 2'b00;
    a1_0 = 24'hABCDEF; a2_0 = 24'h777777; a1_1 = 24'h5A5A5A; a2_1 = 24'hFFFFFF;
    @(negedge clk);
    check({tag, " ack one cycle"}, 48'(ack), 48'd0);
    wait_done(40, n);
    check({tag, " latency"}, 48'(n + 1), 48'd25);
    exp_opc = exp_opc + 16'd1;
    check({tag, " done index"}, 48'(done), v.exp_owner ? 48'd2 : 48'd1);
    check({tag, " w"}, 48'(w), 48'(v.exp_w));
    check({tag, " l"}, 48'(l), 48'(v.exp_l));
    check({tag, " valid"}, 48'(valid), 48'(v.exp_valid));
    check({tag, " owner"}, 48'(owner), 48'(v.exp_owner));
    check({tag, " op_count"}, 48'(op_count), 48'(exp_opc));
    @(negedge clk);
    check({tag, " done one cycle"}, 48'(done), 48'd0);
    check({tag, " idle after"}, 48'(busy), 48'd0);
    check({tag, " w held"}, 48'(w), 48'(v.exp_w));
  endtask

  initial begin
    bit found;
    int n;
    int c;
    int ack_cyc[$];
    logic ack_idx[$];
    logic [1:0] last_ack;
    int done_cnt;
    int proto_bad;
    vec_t v;

    checks = 0; failures = 0; exp_opc = 16'd0;

    vecs[0] = '{2'b01, 24'd3, 24'd5, 24'd0, 24'd0, 1'b0, 32'h0000000F, 6'd4, 1'b1};
    vecs[1] = '{2'b10, 24'd0, 24'd0, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 32'hFE000001, 6'd8, 1'b0};
    vecs[2] = '{2'b01, 24'h123, 24'd0, 24'd0, 24'd0, 1'b0, 32'h00000000, 6'd0, 1'b1};
    vecs[3] = '{2'b10, 24'd0, 24'd0, 24'd2, 24'd2, 1'b1, 32'h00000004, 6'd1, 1'b1};
    vecs[4] = '{2'b11, 24'h001000, 24'h100000, 24'd7, 24'd7, 1'b0, 32'h00000000, 6'd0, 1'b0};
    vecs[5] = '{2'b11, 24'd9, 24'd9, 24'h800000, 24'd2, 1'b1, 32'h01000000, 6'd1, 1'b1};

    reset = 1'b1; req = 2'b00;
    a1_0 = '0; a2_0 = '0; a1_1 = '0; a2_1 = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Table-driven operations.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Both requesters held after reset: alternating grants 27 cycles apart.
    reset = 1'b1;
    @(negedge clk);
    req = 2'b11; a1_0 = 24'd1; a2_0 = 24'd1; a1_1 = 24'd2; a2_1 = 24'd3;
    @(negedge clk);
    reset = 1'b0;
    exp_opc = 16'd0;
    done_cnt = 0; proto_bad = 0; last_ack = 2'b00;
    for (c = 1; c <= 108; c++) begin
      @(negedge clk);
      if ((ack != 2'b00 && done != 2'b00) || ack == 2'b11 || done == 2'b11) proto_bad++;
      if (ack != 2'b00) begin
        ack_cyc.push_back(c);
        ack_idx.push_back(ack[1]);
        last_ack = ack;
      end
      if (done != 2'b00) begin
        done_cnt++;
        if (done != last_ack) proto_bad++;
      end
    end
    req = 2'b00;
    check("rr protocol", 48'(proto_bad), 48'd0);
    check("rr grant count", 48'(ack_cyc.size()), 48'd4);
    check("rr done count", 48'(done_cnt), 48'd4);
    if (ack_cyc.size() == 4) begin
      check("rr first grant", 48'(ack_cyc[0]), 48'd1);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr order %0d", i), 48'(ack_idx[i]), 48'(i % 2));
      end
      for (int i = 1; i < 4; i++) begin
        check($sformatf("rr gap %0d", i), 48'(ack_cyc[i] - ack_cyc[i-1]), 48'd27);
      end
    end
    check("rr op_count", 48'(op_count), 48'd4);
    repeat (5) @(negedge clk);

    // Reset in the middle of the multiply aborts the operation.
    req = 2'b01; a1_0 = 24'd3; a2_0 = 24'd5;
    wait_ack(40, found);
    check("abort ack seen", 48'(found), 48'd1);
    req = 2'b00;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    wait_done(40, n);
    check("abort no done", 48'(n), 48'hFFFFFFFFFFFF);
    check("abort op_count", 48'(op_count), 48'd0);
    exp_opc = 16'd0;
    v = '{2'b01, 24'd2, 24'd2, 24'd0, 24'd0, 1'b0, 32'h00000004, 6'd1, 1'b1};
    run_op("post_abort", v);

    // Requester 1 raises req mid-operation and is granted at the first idle edge.
    req = 2'b01; a1_0 = 24'h123; a2_0 = 24'd0; a1_1 = 24'd5; a2_1 = 24'd6;
    wait_ack(40, found);
    check("late ack0", 48'(ack), 48'd1);
    req = 2'b00;
    repeat (5) @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    check("late busy ignore", 48'(ack), 48'd0);
    wait_done(40, n);
    check("late done0", 48'(done), 48'd1);
    check("late w", 48'(w), 48'd0);
    check("late l", 48'(l), 48'd0);
    check("late valid", 48'(valid), 48'd1);
    @(negedge clk);
    check("late no early ack", 48'(ack), 48'd0);
    @(negedge clk);
    check("late ack1", 48'(ack), 48'd2);
    req = 2'b00;
    wait_done(40, n);
    check("late done1", 48'(done), 48'd2);
    check("late w1", 48'(w), 48'd30);
    check("late l1", 48'(l), 48'd4);
    check("late owner1", 48'(owner), 48'd1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mulpop_arbiter.md
MULPOP_ARBITER -- requirements
Module: mulpop_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 req  in  2  level request per requester (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 a1_0, a2_0  in  24 each  operands of requester 0.
REQ-006 a1_1, a2_1  in  24 each  operands of requester 1.
REQ-007 ack  out  2  one-cycle pulse: operands of that requester captured.
REQ-008 done  out  2  one-cycle pulse: result for that requester valid on w/l/valid.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 w  out  32  low 32 bits of the last product.
REQ-011 l  out  6  count of ones in w (0..32).
REQ-012 valid  out  1  1 = product fits in 32 bits (bits 47:32 all zero).
REQ-013 owner  out  1  index of the requester that owns the current w/l/valid.
REQ-014 op_count  out  16  completed-operation counter.

Function
REQ-015 FSM states: IDLE, MULT, COUNT, DONE; busy = (state != IDLE).
REQ-016 IDLE: at a rising edge with req != 0, select grantee g, latch a1_g/a2_g, clear the 48-bit accumulator and the 5-bit bit index k, set ack[g]=1 for exactly one cycle, go to MULT.
REQ-017 Arbitration: single request: grant it; both requests: grant requester rr, where rr is the round-robin pointer (reset value 0).
REQ-018 On each grant, set rr to the other requester (not g).
REQ-019 MULT: each cycle, add (a1 << k) to the accumulator when latched a2[k]=1, then k = k+1; after the k=23 cycle, go to COUNT (exactly 24 MULT cycles).
REQ-020 The accumulator SHALL be 48 bits wide; no truncation before COUNT.
REQ-021 COUNT (1 cycle): w = acc[31:0]; valid = (acc[47:32] == 0); l = popcount(acc[31:0]); owner = g; done[g] = 1; op_count = op_count + 1, wrapping 0xFFFF -> 0x0000; go to DONE.
REQ-022 DONE (1 cycle): done = 0; go to IDLE.
REQ-023 Latency: done[g] rises 25 clocks after ack[g] rises.
REQ-024 Back-to-back grants SHALL be 27 clocks apart.
REQ-025 Requests arriving while busy SHALL be ignored until IDLE; because req is level-sensitive they remain pending.
REQ-026 No queueing beyond the req level.
REQ-027 A requester holding req high after its ack SHALL be treated as a new request.
REQ-028 Operands are sampled only at the grant edge; changes to a1_x/a2_x afterwards SHALL not affect the result.
REQ-029 w, l, valid and owner SHALL hold their values until the next COUNT.
REQ-030 ack and done SHALL never be asserted for both bits at once, and never in the same cycle as each other.

Reset
REQ-031 While reset is high, regardless of clk: state = IDLE, rr = 0, accumulator = 0, k = 0, ack = 0, done = 0, w = 0, l = 0, valid = 1, owner = 0, op_count = 0.
REQ-032 Reset during MULT, COUNT or DONE SHALL abort the operation with no done pulse and no op_count increment.
REQ-033 The first grant SHALL occur at the first rising edge after reset deasserts with req != 0.

Verification
REQ-034 Requester 0 requests 3 x 5 -> ack[0] one cycle; 25 clocks later done[0] = 1 with w = 0x0000000F, l = 4, valid = 1, owner = 0, op_count = 1.
REQ-035 Requester 1 requests 0xFFFFFF x 0xFFFFFF -> w = 0xFE000001, valid = 0, l = 8, owner = 1.
REQ-036 req = 2'b11 held after reset -> grants in order 0, 1, 0, 1, each 27 clocks apart; each done matches its ack index.
REQ-037 Reset pulsed at the 10th MULT cycle -> all outputs at reset values, no done pulse; a subsequent request of 2 x 2 gives w = 4, l = 1.
REQ-038 Requester 0 requests 0x123 x 0; requester 1 raises req mid-operation -> done[0] with w = 0, l = 0, valid = 1; requester 1 is then granted at the first IDLE edge.
REQ-039 Operands changed one cycle after ack -> result reflects the values latched at the grant edge.
